// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external multiplexed board-bus master.
// Holds the sequencer state encoding and the high-address-word packing.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LA0,
    LA1,
    ACT,
    END
  } bus_state_e;

  localparam int BLE_BIT     = 31;
  localparam int CE_BIT      = 29;
  localparam int HI_ADDR_MSB = 28;
  localparam int CNT_W       = 4;

  // Builds a1[31:16]: BLE (active-low) on bit 31, bit 30 zero, CE (active-low,
  // always selected) on bit 29, and the upper halfword address below them.
  function automatic logic [15:0] pack_hi_word(input logic [HI_ADDR_MSB-16:0] addr_hi,
                                               input logic [1:0]              be);
    logic [31:0] w_word;
    w_word                   = '0;
    w_word[BLE_BIT]          = ~be[0];
    w_word[CE_BIT]           = 1'b0;
    w_word[HI_ADDR_MSB:16]   = addr_hi;
    return w_word[31:16];
  endfunction

endpackage

// File: rtl/ext_bus_ctrl.sv
// Core-side master for the 16-bit multiplexed board bus: sequences one halfword
// request through low/high address latch phases, then a write strobe or read sample.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [28:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] bus_dout,
  output logic        bus_oe,
  input  logic [15:0] bus_din,
  output logic [1:0]  bus_le,
  output logic        bus_bhe_n,
  output logic        bus_we_n
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  bus_state_e r_state;
  bus_state_e w_state_nxt;

  logic             r_write;
  logic [12:0]      r_addr_hi;
  logic [1:0]       r_be;
  logic [15:0]      r_wdata;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [15:0]      r_dout;
  logic [15:0]      r_rdata;

  logic        w_accept;
  logic        w_wait_done;
  logic [15:0] w_dout_nxt;
  logic [1:0]  w_le;
  logic        w_we_n;
  logic        w_bhe_n;
  logic        w_oe;
  logic        w_resp_valid;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_wait_done = (r_wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_dout_nxt   = r_dout;
    w_le         = 2'b00;
    w_we_n       = 1'b1;
    w_bhe_n      = 1'b1;
    w_oe         = 1'b0;
    w_resp_valid = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = LA0;
          w_dout_nxt  = req_addr[15:0];
        end
      end
      LA0: begin
        w_le        = 2'b01;
        w_oe        = 1'b1;
        w_state_nxt = LA1;
        w_dout_nxt  = pack_hi_word(r_addr_hi, r_be);
      end
      LA1: begin
        w_le        = 2'b10;
        w_oe        = 1'b1;
        w_bhe_n     = ~r_be[1];
        w_state_nxt = ACT;
        if (r_write) begin
          w_dout_nxt = r_wdata;
        end
      end
      ACT: begin
        w_bhe_n = ~r_be[1];
        w_oe    = r_write;
        w_we_n  = ~r_write;
        if (w_wait_done) begin
          w_state_nxt = END;
        end
      end
      END: begin
        // Write data stays on the bus one cycle past the strobe for hold time.
        w_bhe_n      = ~r_be[1];
        w_oe         = r_write;
        w_resp_valid = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: request fields are pure datapath qualified by the FSM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write   <= req_write;
      r_addr_hi <= req_addr[28:16];
      r_be      <= req_be;
      r_wdata   <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dout     <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_dout <= w_dout_nxt;

      if (r_state == LA1) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ACT) && !w_wait_done) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end

      // Read data is sampled on the final ACT edge and held until the next read.
      if ((r_state == ACT) && w_wait_done && !r_write) begin
        r_rdata <= bus_din;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = w_resp_valid;
  assign resp_rdata = r_rdata;
  assign bus_dout   = r_dout;
  assign bus_oe     = w_oe;
  assign bus_le     = w_le;
  assign bus_bhe_n  = w_bhe_n;
  assign bus_we_n   = w_we_n;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl with a small byte-lane board memory model;
// a second instance at WAIT_CYCLES=1 checks back-to-back spacing.
module tb_ext_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [28:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] bus_dout;
  logic        bus_oe;
  logic [15:0] bus_din;
  logic [1:0]  bus_le;
  logic        bus_bhe_n;
  logic        bus_we_n;

  logic        r1_req_valid;
  logic        r1_req_ready;
  logic        r1_req_write;
  logic [28:0] r1_req_addr;
  logic [1:0]  r1_req_be;
  logic [15:0] r1_req_wdata;
  logic        r1_resp_valid;
  logic [15:0] r1_resp_rdata;
  logic [15:0] r1_bus_dout;
  logic        r1_bus_oe;
  logic [1:0]  r1_bus_le;
  logic        r1_bus_bhe_n;
  logic        r1_bus_we_n;

  int n_checks = 0;
  int n_errors = 0;

  ext_bus_ctrl #(.WAIT_CYCLES(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus_dout   (bus_dout),
    .bus_oe     (bus_oe),
    .bus_din    (bus_din),
    .bus_le     (bus_le),
    .bus_bhe_n  (bus_bhe_n),
    .bus_we_n   (bus_we_n)
  );

  ext_bus_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (r1_req_valid),
    .req_ready  (r1_req_ready),
    .req_write  (r1_req_write),
    .req_addr   (r1_req_addr),
    .req_be     (r1_req_be),
    .req_wdata  (r1_req_wdata),
    .resp_valid (r1_resp_valid),
    .resp_rdata (r1_resp_rdata),
    .bus_dout   (r1_bus_dout),
    .bus_oe     (r1_bus_oe),
    .bus_din    (16'h0000),
    .bus_le     (r1_bus_le),
    .bus_bhe_n  (r1_bus_bhe_n),
    .bus_we_n   (r1_bus_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory model: latches a0/a1 on the latch enables, writes enabled lanes under we_n.
  logic [15:0] mem [0:255];
  logic [15:0] b_a0;
  logic        b_ble_n;

  always @(posedge clk) begin
    if (bus_le[0]) b_a0 <= bus_dout;
    if (bus_le[1]) b_ble_n <= bus_dout[15];
    if (!bus_we_n) begin
      if (!b_ble_n)   mem[b_a0[7:0]][7:0]  <= bus_dout[7:0];
      if (!bus_bhe_n) mem[b_a0[7:0]][15:8] <= bus_dout[15:8];
    end
  end

  assign bus_din = mem[b_a0[7:0]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [28:0] addr,
                         input logic [1:0] be, input logic [15:0] wd,
                         input logic [15:0] exp_hi, input logic exp_bhe_n,
                         input logic [15:0] exp_rd);
    req_write = wr;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    req_valid = 1'b1;
    check({tag, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~addr;
    req_be    = ~be;
    req_wdata = ~wd;
    check({tag, "_la0_le"},   bus_le, 2'b01);
    check({tag, "_la0_dout"}, bus_dout, addr[15:0]);
    check({tag, "_la0_oe"},   bus_oe, 1);
    check({tag, "_la0_bhe"},  bus_bhe_n, 1);
    tick();
    check({tag, "_la1_le"},   bus_le, 2'b10);
    check({tag, "_la1_dout"}, bus_dout, exp_hi);
    check({tag, "_la1_bhe"},  bus_bhe_n, exp_bhe_n);
    check({tag, "_la1_we"},   bus_we_n, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check({tag, "_act_le"},   bus_le, 2'b00);
      check({tag, "_act_we"},   bus_we_n, !wr);
      check({tag, "_act_oe"},   bus_oe, wr);
      check({tag, "_act_bhe"},  bus_bhe_n, exp_bhe_n);
      check({tag, "_act_resp"}, resp_valid, 0);
      if (wr) check({tag, "_act_dout"}, bus_dout, wd);
    end
    tick();
    check({tag, "_end_resp"},  resp_valid, 1);
    check({tag, "_end_we"},    bus_we_n, 1);
    check({tag, "_end_le"},    bus_le, 2'b00);
    check({tag, "_end_rdata"}, resp_rdata, exp_rd);
    if (wr) begin
      check({tag, "_end_dout"}, bus_dout, wd);
      check({tag, "_end_oe"},   bus_oe, 1);
    end
    tick();
    check({tag, "_idle_ready"}, req_ready, 1);
    check({tag, "_idle_resp"},  resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int rsp [3];
    int idx;
    int n_rsp;
    logic take;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_be       = 2'b00;
    req_wdata    = '0;
    r1_req_valid = 1'b0;
    r1_req_write = 1'b0;
    r1_req_addr  = '0;
    r1_req_be    = 2'b11;
    r1_req_wdata = '0;
    tick();
    tick();
    reset = 1'b1;

    check("rst_le",    bus_le, 2'b00);
    check("rst_we",    bus_we_n, 1);
    check("rst_bhe",   bus_bhe_n, 1);
    check("rst_oe",    bus_oe, 0);
    check("rst_dout",  bus_dout, 16'h0000);
    check("rst_resp",  resp_valid, 0);
    check("rst_rdata", resp_rdata, 16'h0000);
    check("rst_ready", req_ready, 1);

    run_txn("wr_full", 1, 29'h0000012, 2'b11, 16'hBEEF, 16'h0000, 0, 16'h0000);
    check("mem_12_full", mem[8'h12], 16'hBEEF);
    run_txn("rd_full", 0, 29'h0000012, 2'b11, 16'h0000, 16'h0000, 0, 16'hBEEF);
    run_txn("wr_lo", 1, 29'h0000012, 2'b01, 16'h1234, 16'h0000, 1, 16'hBEEF);
    run_txn("rd_lo", 0, 29'h0000012, 2'b11, 16'h0000, 16'h0000, 0, 16'hBE34);
    run_txn("wr_hi", 1, 29'h0000012, 2'b10, 16'h5600, 16'h8000, 0, 16'hBE34);
    run_txn("rd_hi", 0, 29'h0000012, 2'b11, 16'h0000, 16'h0000, 0, 16'h5634);
    run_txn("wr_ahi", 1, 29'h1ABC0034, 2'b11, 16'hA5A5, 16'h1ABC, 0, 16'h5634);
    run_txn("wr_be0", 1, 29'h1ABC0034, 2'b00, 16'hFFFF, 16'h9ABC, 1, 16'h5634);
    check("mem_34_be0", mem[8'h34], 16'hA5A5);
    run_txn("rd_ahi", 0, 29'h1ABC0034, 2'b11, 16'h0000, 16'h1ABC, 0, 16'hA5A5);

    // Reset during the first ACT cycle of a write.
    req_write = 1'b1;
    req_addr  = 29'h0000040;
    req_be    = 2'b11;
    req_wdata = 16'h7777;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("mid_act_we", bus_we_n, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_we",    bus_we_n, 1);
    check("abort_le",    bus_le, 2'b00);
    check("abort_oe",    bus_oe, 0);
    check("abort_resp",  resp_valid, 0);
    check("abort_dout",  bus_dout, 16'h0000);
    check("abort_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_resp", resp_valid, 0);
    end

    // Back-to-back writes at WAIT_CYCLES=2 with req_valid held.
    idx   = 0;
    n_rsp = 0;
    req_write = 1'b1;
    req_be    = 2'b11;
    req_addr  = 29'h0000050;
    req_wdata = 16'h1111;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      take = req_ready;
      if (take) acc[idx] = c;
      if (resp_valid) n_rsp++;
      tick();
      if (take) begin
        idx++;
        if (idx < 3) begin
          req_addr  = 29'h0000050 + 29'(idx);
          req_wdata = 16'h1111 * 16'(idx + 1);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_accepted", idx, 3);
    if (idx == 3) begin
      check("b2b_gap0", acc[1] - acc[0], 6);
      check("b2b_gap1", acc[2] - acc[1], 6);
    end
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) n_rsp++;
      tick();
    end
    check("b2b_resp_count", n_rsp, 3);
    check("b2b_mem_52", mem[8'h52], 16'h3333);

    // Back-to-back reads at WAIT_CYCLES=1.
    idx   = 0;
    n_rsp = 0;
    r1_req_addr  = 29'h0000001;
    r1_req_valid = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 3; c++) begin
      take = r1_req_ready && r1_req_valid;
      if (take && idx < 3) acc[idx] = c;
      if (r1_resp_valid) begin
        rsp[n_rsp] = c;
        n_rsp++;
      end
      tick();
      if (take) begin
        idx++;
        if (idx >= 3) r1_req_valid = 1'b0;
      end
    end
    check("w1_accepted", idx, 3);
    check("w1_resp_count", n_rsp, 3);
    if (idx == 3 && n_rsp == 3) begin
      check("w1_ready_gap0", acc[1] - acc[0], 5);
      check("w1_ready_gap1", acc[2] - acc[1], 5);
      check("w1_resp_gap0",  rsp[1] - rsp[0], 5);
      check("w1_resp_gap1",  rsp[2] - rsp[1], 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
